cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shared-memory front end for the split L1 caches. It accepts block-fill requests from the instruction and data caches and write-through stores from the data cache, then drives the single 4-cycle pipelined main memory. Returning words are sequenced into the owning cache's data array, followed by one tag-write cycle. It sits between the cache controller's icache/dcache arrays and the main memory, and produces the pipeline stall signals.

## Interface
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width. A block is fixed at 8 words / 16 bytes: offset is addr[3:1], block address is addr[15:4].

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- i_miss  in  1  icache miss, held until the fill completes.
- i_miss_addr  in  16  faulting fetch address.
- d_miss  in  1  dcache miss (load or store), held until the fill completes.
- d_miss_addr  in  16  faulting data address.
- d_wr  in  1  write-through store request.
- d_wr_addr  in  16  store address.
- d_wr_data  in  16  store data.
- mem_addr  out  16  memory address.
- mem_enable  out  1  memory request strobe.
- mem_wr  out  1  1 = write, 0 = read.
- mem_data_in  out  16  memory write data.
- mem_data_out  in  16  memory read data.
- mem_data_valid  in  1  read data valid.
- fill_addr  out  16  {blk, fill_word, 1'b0}, used by the caches to index the fill.
- fill_word  out  3  word offset of the current returned word.
- fill_data  out  16  equals mem_data_out.
- fill_we_i / fill_we_d  out  1 each  data-array write enable for the icache / dcache.
- tag_we_i / tag_we_d  out  1 each  tag write (valid=1, tag=blk[11:6]) pulse.
- if_stall  out  1  stall fetch.
- mem_stall  out  1  stall the memory stage.

## Operation
- States: IDLE, FILL, TAG. Registers: owner (0 = D, 1 = I), blk[11:0], iss_cnt[3:0] (0..8), rcv_cnt[2:0].
- IDLE:
  - If d_miss: owner=D, blk=d_miss_addr[15:4], go to FILL.
  - Else if i_miss: owner=I, blk=i_miss_addr[15:4], go to FILL.
  - Priority is dcache over icache.
- IDLE, d_wr & ~d_miss: issue the write in the same cycle, combinationally.
  - mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data.
  - The store completes that cycle.
  - A concurrent i_miss is latched in the same cycle; the fill starts next cycle.
- d_wr & d_miss (store miss, write-allocate): the fill runs first. The store is issued in the first IDLE cycle where d_miss is low.
- FILL, issuing: while iss_cnt<8, drive mem_enable=1, mem_wr=0, mem_addr={blk, iss_cnt[2:0], 1'b0}, then iss_cnt++. Requests go out on consecutive cycles.
- FILL, receiving: on mem_data_valid, assert fill_we_<owner> for one cycle at fill_word=rcv_cnt, then rcv_cnt++.
  - Completion is counted by valids and does not depend on memory latency.
  - When rcv_cnt==7 and mem_data_valid, go to TAG.
- TAG: tag_we_<owner>=1 for one cycle; clear counters; go to IDLE.
- Stalls (combinational):
  - if_stall = i_miss | (state!=IDLE & owner==I).
  - mem_stall = d_miss | (state!=IDLE & owner==D) | (d_wr & state!=IDLE).
- d_wr while state!=IDLE is held (stalled) and never reaches memory mid-fill.
- Miss inputs dropping mid-fill: ignored; the fill always completes.
- mem_data_valid in IDLE or TAG: ignored, no write enables.
- Reset (rst low at any edge, including mid-fill):
  - state=IDLE, counters=0, owner=D, blk=0.
  - While rst is low, every output is 0.
  - A partially filled block stays invalid because its tag was never written.

## Timing
- Miss sampled in IDLE at cycle T: FILL from T+1; reads issued T+1..T+8.
- With 4-cycle memory: data valid T+5..T+12, fill_we on those cycles, words 0..7 in order.
- TAG at T+13; IDLE at T+14; the requester sees a hit at T+14.
- Stall for the requester is high T..T+13 (14 cycles).
- Back-to-back: a second miss already asserted at T+14 starts FILL at T+15.
- The store path adds zero cycles when IDLE.

## Test plan
- i_miss at addr 0x1236, memory preloaded with word k = 0xA000+k:
  - reads to 0x1230..0x123E on 8 consecutive cycles.
  - fill_we_i with fill_word 0..7 carrying data 0xA000..0xA007.
  - tag_we_i one cycle; if_stall high exactly 14 cycles; mem_stall stays 0.
- i_miss 0x0040 and d_miss 0x8000 asserted together:
  - dcache fill first (addr 0x8000..0x800E, tag_we_d).
  - icache fill begins the cycle after IDLE is re-entered.
  - if_stall held high throughout.
- d_wr addr 0x0100, data 0xBEEF in IDLE: same-cycle mem_enable=1, mem_wr=1, mem_addr=0x0100, mem_data_in=0xBEEF; mem_stall=0.
- d_wr 0x0200 concurrent with i_miss 0x0400:
  - the write is issued in cycle T.
  - the first fill read 0x0400 is issued at T+1.
- d_wr 0x0300 & d_miss 0x0300 together:
  - fill completes (tag_we_d) first.
  - the write is issued on the first IDLE cycle after d_miss drops; mem_stall stays high until then.
- rst low at T+7 of a fill:
  - all outputs 0 next edge; no tag_we.
  - stray mem_data_valid pulses afterwards produce no fill_we.
  - a new i_miss after release performs a full 8-word fill.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - main memory bus between the cache arbiter and memory
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_enable;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_data_valid;

  // Arbiter side: drives requests, receives read data.
  modport master (
    output mem_addr, mem_enable, mem_wr, mem_data_in,
    input  mem_data_out, mem_data_valid
  );

  // Memory side.
  modport slave (
    input  mem_addr, mem_enable, mem_wr, mem_data_in,
    output mem_data_out, mem_data_valid
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache block-fill and write-through arbiter for main memory
module cache_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  cache_mem_arbiter_if.master mem,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [2:0]        fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic              tag_we_i,
  output logic              tag_we_d,
  output logic              if_stall,
  output logic              mem_stall
);
  localparam int BLK_W = ADDR_W - 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_TAG  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_owner_i;
  logic [BLK_W-1:0] r_blk;
  logic [3:0]       r_iss_cnt;
  logic [2:0]       r_rcv_cnt;

  logic              w_latch_d;
  logic              w_latch_i;
  logic              w_issue;
  logic              w_recv;
  logic              w_store;
  logic              w_tag;
  logic              w_busy;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data_in;

  // Only the block part of the miss addresses matters; the offset bits are
  // folded here so they are visibly consumed.
  logic w_unused_offsets;
  assign w_unused_offsets = ^{i_miss_addr[3:0], d_miss_addr[3:0]};

  // State, owner, block and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_owner_i <= 1'b0;
      r_blk     <= '0;
      r_iss_cnt <= '0;
      r_rcv_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_latch_d) begin
        r_owner_i <= 1'b0;
        r_blk     <= d_miss_addr[ADDR_W-1:4];
      end else if (w_latch_i) begin
        r_owner_i <= 1'b1;
        r_blk     <= i_miss_addr[ADDR_W-1:4];
      end
      if (w_tag) begin
        r_iss_cnt <= '0;
        r_rcv_cnt <= '0;
      end else begin
        if (w_issue) r_iss_cnt <= r_iss_cnt + 4'd1;
        if (w_recv)  r_rcv_cnt <= r_rcv_cnt + 3'd1;
      end
    end
  end

  // Next state plus per-state request, store and tag decisions.
  always_comb begin
    w_next_state  = r_state;
    w_latch_d     = 1'b0;
    w_latch_i     = 1'b0;
    w_issue       = 1'b0;
    w_recv        = 1'b0;
    w_store       = 1'b0;
    w_tag         = 1'b0;
    w_mem_addr    = '0;
    w_mem_data_in = '0;
    case (r_state)
      S_IDLE: begin
        // A store that is also a miss waits for its own fill (write-allocate).
        w_store = d_wr & ~d_miss;
        if (w_store) begin
          w_mem_addr    = d_wr_addr;
          w_mem_data_in = d_wr_data;
        end
        if (d_miss) begin
          w_latch_d    = 1'b1;
          w_next_state = S_FILL;
        end else if (i_miss) begin
          w_latch_i    = 1'b1;
          w_next_state = S_FILL;
        end
      end
      S_FILL: begin
        // Reads stream out back to back while returns are counted independently,
        // so the fill length tracks valids rather than memory latency.
        w_issue = ~r_iss_cnt[3];
        if (w_issue) w_mem_addr = {r_blk, r_iss_cnt[2:0], 1'b0};
        w_recv = mem.mem_data_valid;
        if (w_recv && (r_rcv_cnt == 3'd7)) w_next_state = S_TAG;
      end
      S_TAG: begin
        w_tag        = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_busy = (r_state != S_IDLE);

  // Every output is forced low while reset is held.
  assign mem.mem_enable  = rst & (w_issue | w_store);
  assign mem.mem_wr      = rst & w_store;
  assign mem.mem_addr    = rst ? w_mem_addr : '0;
  assign mem.mem_data_in = rst ? w_mem_data_in : '0;

  assign fill_word = rst ? r_rcv_cnt : '0;
  assign fill_addr = rst ? {r_blk, r_rcv_cnt, 1'b0} : '0;
  assign fill_data = rst ? mem.mem_data_out : '0;
  assign fill_we_i = rst & w_recv & r_owner_i;
  assign fill_we_d = rst & w_recv & ~r_owner_i;
  assign tag_we_i  = rst & w_tag & r_owner_i;
  assign tag_we_d  = rst & w_tag & ~r_owner_i;

  assign if_stall  = rst & (i_miss | (w_busy & r_owner_i));
  assign mem_stall = rst & (d_miss | (w_busy & ~r_owner_i) | (d_wr & w_busy));
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        d_wr;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic [15:0] fill_addr;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        fill_we_i, fill_we_d, tag_we_i, tag_we_d;
  logic        if_stall, mem_stall;
  logic        stray_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter_if mem_if ();

  cache_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .d_wr        (d_wr),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem         (mem_if.master),
    .fill_addr   (fill_addr),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .fill_we_i   (fill_we_i),
    .fill_we_d   (fill_we_d),
    .tag_we_i    (tag_we_i),
    .tag_we_d    (tag_we_d),
    .if_stall    (if_stall),
    .mem_stall   (mem_stall)
  );

  // 4-cycle pipelined memory: a read requested in cycle n returns in cycle n+4
  // with data 0xA000 + word offset.
  logic [3:0]  r_vp = '0;
  logic [15:0] r_ap [4];
  always @(posedge clk) begin
    r_vp    <= {r_vp[2:0], mem_if.mem_enable & ~mem_if.mem_wr};
    r_ap[0] <= mem_if.mem_addr;
    for (int i = 1; i < 4; i++) r_ap[i] <= r_ap[i-1];
  end
  assign mem_if.mem_data_valid = r_vp[3] | stray_valid;
  assign mem_if.mem_data_out   = 16'hA000 + {13'd0, r_ap[3][3:1]};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks cycles T+1..T+13 of a fill whose miss was sampled in cycle T.
  task automatic fill_seq(input bit is_i, input logic [15:0] base, input bit e_if, input bit e_mem);
    int k;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c <= 8) begin
        chk("rd_en", {15'd0, mem_if.mem_enable}, 16'd1);
        chk("rd_wr", {15'd0, mem_if.mem_wr}, 16'd0);
        chk("rd_addr", mem_if.mem_addr, base + 16'(2 * (c - 1)));
      end else begin
        chk("rd_done", {15'd0, mem_if.mem_enable}, 16'd0);
      end
      if (c >= 5 && c <= 12) begin
        k = c - 5;
        chk("fill_we_i", {15'd0, fill_we_i}, {15'd0, is_i});
        chk("fill_we_d", {15'd0, fill_we_d}, {15'd0, ~is_i});
        chk("fill_word", {13'd0, fill_word}, 16'(k));
        chk("fill_data", fill_data, 16'hA000 + 16'(k));
        chk("fill_addr", fill_addr, base + 16'(2 * k));
      end else begin
        chk("fill_we_off", {14'd0, fill_we_i, fill_we_d}, 16'd0);
      end
      chk("tag_we_i", {15'd0, tag_we_i}, {15'd0, is_i && c == 13});
      chk("tag_we_d", {15'd0, tag_we_d}, {15'd0, !is_i && c == 13});
      chk("if_stall_fill", {15'd0, if_stall}, {15'd0, e_if});
      chk("mem_stall_fill", {15'd0, mem_stall}, {15'd0, e_mem});
    end
  endtask

  initial begin
    rst = 1'b0; stray_valid = 1'b0;
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    d_miss = 1'b0; d_miss_addr = 16'h0;
    d_wr = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'h5555;
    tick();
    // While reset is held every output stays low despite active requests.
    chk("rst_mem_en", {15'd0, mem_if.mem_enable}, 16'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 16'd0);
    chk("rst_if_stall", {15'd0, if_stall}, 16'd0);
    chk("rst_mem_stall", {15'd0, mem_stall}, 16'd0);
    i_miss = 1'b0; d_wr = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("idle_mem_en", {15'd0, mem_if.mem_enable}, 16'd0);
    chk("idle_stalls", {14'd0, if_stall, mem_stall}, 16'd0);

    // icache fill of block 0x123x; if_stall high T..T+13.
    tick();
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    #1;
    chk("t1_if_stall_T", {15'd0, if_stall}, 16'd1);
    chk("t1_mem_en_T", {15'd0, mem_if.mem_enable}, 16'd0);
    fill_seq(1'b1, 16'h1230, 1'b1, 1'b0);
    tick();
    i_miss = 1'b0;
    #1;
    chk("t1_if_stall_end", {15'd0, if_stall}, 16'd0);
    chk("t1_mem_en_end", {15'd0, mem_if.mem_enable}, 16'd0);

    // Simultaneous misses: dcache served first, icache right after.
    tick();
    d_miss = 1'b1; d_miss_addr = 16'h8000;
    i_miss = 1'b1; i_miss_addr = 16'h0040;
    #1;
    chk("t2_stalls_T", {14'd0, if_stall, mem_stall}, 16'd3);
    fill_seq(1'b0, 16'h8000, 1'b1, 1'b1);
    tick();
    d_miss = 1'b0;
    #1;
    chk("t2_reidle_if_stall", {15'd0, if_stall}, 16'd1);
    chk("t2_reidle_mem_stall", {15'd0, mem_stall}, 16'd0);
    chk("t2_reidle_mem_en", {15'd0, mem_if.mem_enable}, 16'd0);
    fill_seq(1'b1, 16'h0040, 1'b1, 1'b0);
    tick();
    i_miss = 1'b0;
    #1;
    chk("t2_if_stall_end", {15'd0, if_stall}, 16'd0);

    // Write-through store in IDLE: same-cycle, no stall.
    tick();
    d_wr = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'hBEEF;
    #1;
    chk("t3_en", {15'd0, mem_if.mem_enable}, 16'd1);
    chk("t3_wr", {15'd0, mem_if.mem_wr}, 16'd1);
    chk("t3_addr", mem_if.mem_addr, 16'h0100);
    chk("t3_data", mem_if.mem_data_in, 16'hBEEF);
    chk("t3_mem_stall", {15'd0, mem_stall}, 16'd0);
    tick();
    d_wr = 1'b0;
    #1;
    chk("t3_after_en", {15'd0, mem_if.mem_enable}, 16'd0);

    // Store concurrent with an icache miss: write now, fill read next cycle.
    tick();
    d_wr = 1'b1; d_wr_addr = 16'h0200; d_wr_data = 16'h1111;
    i_miss = 1'b1; i_miss_addr = 16'h0400;
    #1;
    chk("t4_wr", {14'd0, mem_if.mem_enable, mem_if.mem_wr}, 16'd3);
    chk("t4_addr", mem_if.mem_addr, 16'h0200);
    chk("t4_data", mem_if.mem_data_in, 16'h1111);
    d_wr = 1'b0;
    fill_seq(1'b1, 16'h0400, 1'b1, 1'b0);
    tick();
    i_miss = 1'b0;
    #1;
    chk("t4_if_stall_end", {15'd0, if_stall}, 16'd0);

    // Store miss: fill first, then the store once d_miss drops.
    tick();
    d_wr = 1'b1; d_wr_addr = 16'h0300; d_wr_data = 16'h1234;
    d_miss = 1'b1; d_miss_addr = 16'h0300;
    #1;
    chk("t5_en_T", {15'd0, mem_if.mem_enable}, 16'd0);
    chk("t5_mem_stall_T", {15'd0, mem_stall}, 16'd1);
    fill_seq(1'b0, 16'h0300, 1'b0, 1'b1);
    tick();
    d_miss = 1'b0;
    #1;
    chk("t5_wr", {14'd0, mem_if.mem_enable, mem_if.mem_wr}, 16'd3);
    chk("t5_addr", mem_if.mem_addr, 16'h0300);
    chk("t5_data", mem_if.mem_data_in, 16'h1234);
    chk("t5_mem_stall_end", {15'd0, mem_stall}, 16'd0);
    tick();
    d_wr = 1'b0;

    // Reset at T+7 of an icache fill.
    tick();
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    for (int c = 1; c <= 6; c++) tick();
    tick();
    rst = 1'b0; i_miss = 1'b0;
    #1;
    chk("t6_rst_en", {15'd0, mem_if.mem_enable}, 16'd0);
    chk("t6_rst_fill_we", {14'd0, fill_we_i, fill_we_d}, 16'd0);
    chk("t6_rst_if_stall", {15'd0, if_stall}, 16'd0);
    chk("t6_rst_fill_data", fill_data, 16'd0);
    tick();
    chk("t6_rst2_outs", {12'd0, fill_we_i, tag_we_i, if_stall, mem_if.mem_enable}, 16'd0);
    tick();
    rst = 1'b1;
    #1;
    // Late returns from the aborted fill arrive in IDLE and must be ignored.
    chk("t6_late_valid_seen", {15'd0, mem_if.mem_data_valid}, 16'd1);
    chk("t6_late_fill_we", {14'd0, fill_we_i, fill_we_d}, 16'd0);
    chk("t6_late_tag_we", {14'd0, tag_we_i, tag_we_d}, 16'd0);
    chk("t6_late_en", {15'd0, mem_if.mem_enable}, 16'd0);
    tick();
    chk("t6_late2_fill_we", {14'd0, fill_we_i, fill_we_d}, 16'd0);
    tick();
    stray_valid = 1'b1;
    #1;
    chk("t6_stray_fill_we", {14'd0, fill_we_i, fill_we_d}, 16'd0);
    chk("t6_stray_tag_we", {14'd0, tag_we_i, tag_we_d}, 16'd0);
    tick();
    chk("t6_stray2_fill_we", {14'd0, fill_we_i, fill_we_d}, 16'd0);
    stray_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    #1;
    chk("t6_refill_stall_T", {15'd0, if_stall}, 16'd1);
    fill_seq(1'b1, 16'h1230, 1'b1, 1'b0);
    tick();
    i_miss = 1'b0;
    #1;
    chk("t6_refill_end", {15'd0, if_stall}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
